// File: rtl/elevator_ctrl_nfloor.sv
// N-floor elevator controller: latches per-floor calls into a pending register and
// serves them in SCAN order, with per-floor travel and door dwell timed in cycles.
module elevator_ctrl_nfloor #(
    parameter int FLOORS        = 8,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3,
    localparam int FW           = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Enable,
    input  logic [FLOORS-1:0] Call,
    output logic [FLOORS-1:0] Floor_LED,
    output logic [FW-1:0]     Floor_Num,
    output logic              Moving_Up,
    output logic              Moving_Down,
    output logic              Door_Open,
    output logic [FLOORS-1:0] Pending
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     floor_q, floor_d;
    logic              dir_q, dir_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic [TW-1:0]     travel_q, travel_d;
    logic [DW-1:0]     door_q, door_d;
    logic [FLOORS-1:0] led_q, led_d;
    logic              mv_up_q, mv_up_d;
    logic              mv_dn_q, mv_dn_d;
    logic              door_open_q, door_open_d;

    logic [FLOORS-1:0] above_v, below_v, clr, call_eff;
    logic              above, below, ahead, behind, here;
    logic              decide, step_edge, step_oob;
    logic [FW-1:0]     next_floor;

    for (genvar gi = 0; gi < FLOORS; gi++) begin : g_side
        assign above_v[gi] = pending_q[gi] && (gi > int'(floor_q));
        assign below_v[gi] = pending_q[gi] && (gi < int'(floor_q));
    end

    assign above      = |above_v;
    assign below      = |below_v;
    assign ahead      = dir_q ? above : below;
    assign behind     = dir_q ? below : above;
    assign here       = pending_q[floor_q];
    assign next_floor = dir_q ? floor_q + FW'(1) : floor_q - FW'(1);
    assign step_edge  = (state_q == S_MOVE) && Enable && (travel_q == TW'(TRAVEL_CYCLES - 1));
    assign step_oob   = step_edge && (dir_q ? (floor_q == FW'(FLOORS - 1)) : (floor_q == '0));

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_d    = dir_q;
        travel_d = travel_q;
        door_d   = door_q;
        clr      = '0;
        decide   = 1'b0;
        call_eff = Call;
        // A re-call of the open-door floor extends the dwell instead of queueing a new stop.
        if (state_q == S_DOOR && Enable) begin
            call_eff[floor_q] = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (Enable) begin
                    decide = 1'b1;
                end
            end
            S_MOVE: begin
                if (Enable) begin
                    if (travel_q == TW'(TRAVEL_CYCLES - 1)) begin
                        travel_d = '0;
                        if (step_oob) begin
                            state_d = S_IDLE;
                        end else begin
                            floor_d = next_floor;
                            if (pending_q[next_floor]) begin
                                state_d         = S_DOOR;
                                clr[next_floor] = 1'b1;
                                door_d          = '0;
                            end
                        end
                    end else begin
                        travel_d = travel_q + TW'(1);
                    end
                end
            end
            S_DOOR: begin
                if (Enable) begin
                    if (Call[floor_q]) begin
                        door_d = '0;
                    end else if (door_q == DW'(DOOR_CYCLES - 1)) begin
                        decide = 1'b1;
                    end else begin
                        door_d = door_q + DW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (decide) begin
            if (here) begin
                state_d      = S_DOOR;
                clr[floor_q] = 1'b1;
                door_d       = '0;
            end else if (ahead) begin
                state_d  = S_MOVE;
                travel_d = '0;
            end else if (behind) begin
                state_d  = S_MOVE;
                dir_d    = ~dir_q;
                travel_d = '0;
            end else begin
                state_d = S_IDLE;
            end
        end

        pending_d = (pending_q | call_eff) & ~clr;

        led_d          = '0;
        led_d[floor_d] = 1'b1;
        mv_up_d        = (state_d == S_MOVE) && dir_d;
        mv_dn_d        = (state_d == S_MOVE) && !dir_d;
        door_open_d    = (state_d == S_DOOR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            floor_q     <= '0;
            dir_q       <= 1'b1;
            pending_q   <= '0;
            travel_q    <= '0;
            door_q      <= '0;
            led_q       <= FLOORS'(1);
            mv_up_q     <= 1'b0;
            mv_dn_q     <= 1'b0;
            door_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            dir_q       <= dir_d;
            pending_q   <= pending_d;
            travel_q    <= travel_d;
            door_q      <= door_d;
            led_q       <= led_d;
            mv_up_q     <= mv_up_d;
            mv_dn_q     <= mv_dn_d;
            door_open_q <= door_open_d;
        end
    end

    assign Floor_LED   = led_q;
    assign Floor_Num   = floor_q;
    assign Moving_Up   = mv_up_q;
    assign Moving_Down = mv_dn_q;
    assign Door_Open   = door_open_q;
    assign Pending     = pending_q;

    a_no_step_past_end: assert property (@(posedge CLK) disable iff (RST) !step_oob);

endmodule

// File: tb/tb_elevator_ctrl_nfloor.sv
// Bench for elevator_ctrl_nfloor: directed scenarios plus randomized traffic checked
// against a countdown-based behavioural model of the SCAN controller.
module tb_elevator_ctrl_nfloor;

    localparam int F  = 8;
    localparam int T  = 4;
    localparam int D  = 3;
    localparam int FW = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          Enable = 1'b1;
    logic [F-1:0]  Call = '0;
    logic [F-1:0]  Floor_LED;
    logic [FW-1:0] Floor_Num;
    logic          Moving_Up, Moving_Down, Door_Open;
    logic [F-1:0]  Pending;

    int checks = 0;
    int errors = 0;

    elevator_ctrl_nfloor #(.FLOORS(F), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
        .CLK(CLK), .RST(RST), .Enable(Enable), .Call(Call),
        .Floor_LED(Floor_LED), .Floor_Num(Floor_Num),
        .Moving_Up(Moving_Up), .Moving_Down(Moving_Down),
        .Door_Open(Door_Open), .Pending(Pending)
    );

    always #5 CLK = ~CLK;

    // Model: mode 0 = idle, 1 = travelling, 2 = door open; m_left counts cycles remaining.
    int m_floor, m_mode, m_dir, m_left;
    bit m_pend[F];

    task automatic model_reset();
        m_floor = 0; m_mode = 0; m_dir = 1; m_left = 0;
        for (int i = 0; i < F; i++) m_pend[i] = 1'b0;
    endtask

    function automatic logic [F-1:0] m_pend_vec();
        logic [F-1:0] v = '0;
        for (int i = 0; i < F; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_step(input logic [F-1:0] c, input logic en);
        bit served[F];
        bit newp[F];
        int n_above = 0;
        int n_below = 0;
        int ahead, behind;
        bit do_decide = 1'b0;
        for (int i = 0; i < F; i++) begin
            served[i] = 1'b0;
            newp[i]   = m_pend[i] | c[i];
            if (m_pend[i] && i > m_floor) n_above++;
            if (m_pend[i] && i < m_floor) n_below++;
        end
        if (en && m_mode == 2) newp[m_floor] = m_pend[m_floor];
        if (en) begin
            if (m_mode == 0) begin
                do_decide = 1'b1;
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) begin
                    m_floor += (m_dir != 0) ? 1 : -1;
                    if (m_floor >= 0 && m_floor < F && m_pend[m_floor]) begin
                        m_mode = 2; served[m_floor] = 1'b1; m_left = D;
                    end else begin
                        m_left = T;
                    end
                end
            end else begin
                if (c[m_floor]) m_left = D;
                else begin
                    m_left--;
                    if (m_left == 0) do_decide = 1'b1;
                end
            end
        end
        if (do_decide) begin
            ahead  = (m_dir != 0) ? n_above : n_below;
            behind = (m_dir != 0) ? n_below : n_above;
            if (m_pend[m_floor]) begin
                m_mode = 2; served[m_floor] = 1'b1; m_left = D;
            end else if (ahead > 0) begin
                m_mode = 1; m_left = T;
            end else if (behind > 0) begin
                m_dir = (m_dir != 0) ? 0 : 1; m_mode = 1; m_left = T;
            end else begin
                m_mode = 0;
            end
        end
        for (int i = 0; i < F; i++) m_pend[i] = newp[i] & !served[i];
    endtask

    task automatic cyc();
        model_step(Call, Enable);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        Call = 8'h80;
        cyc();
        Call = '0;
        repeat (6) cyc();
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (Floor_LED !== 8'b0000_0001 || Floor_Num !== 3'd0 || Pending !== 8'h00 ||
            Moving_Up !== 1'b0 || Moving_Down !== 1'b0 || Door_Open !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got led=%b num=%0d pend=%h up=%b dn=%b door=%b, expected led=00000001 num=0 pend=00 up=0 dn=0 door=0",
                     Floor_LED, Floor_Num, Pending, Moving_Up, Moving_Down, Door_Open);
        end
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single_trip();
        do_reset();
        Call = 8'h04;
        cyc();
        Call = '0;
        checks++;
        if (Pending !== 8'h04 || Moving_Up !== 1'b0) begin
            errors++;
            $display("FAIL trip_E0: got pend=%h up=%b, expected pend=04 up=0", Pending, Moving_Up);
        end
        cyc();
        checks++;
        if (Moving_Up !== 1'b1 || Floor_Num !== 3'd0) begin
            errors++;
            $display("FAIL trip_E1: got up=%b num=%0d, expected up=1 num=0", Moving_Up, Floor_Num);
        end
        repeat (4) cyc();
        checks++;
        if (Floor_Num !== 3'd1 || Moving_Up !== 1'b1) begin
            errors++;
            $display("FAIL trip_E5: got num=%0d up=%b, expected num=1 up=1", Floor_Num, Moving_Up);
        end
        repeat (4) cyc();
        checks++;
        if (Floor_Num !== 3'd2 || Door_Open !== 1'b1 || Moving_Up !== 1'b0 || Pending !== 8'h00) begin
            errors++;
            $display("FAIL trip_E9: got num=%0d door=%b up=%b pend=%h, expected num=2 door=1 up=0 pend=00",
                     Floor_Num, Door_Open, Moving_Up, Pending);
        end
        repeat (2) cyc();
        checks++;
        if (Door_Open !== 1'b1) begin
            errors++;
            $display("FAIL trip_E11: got door=%b, expected door=1", Door_Open);
        end
        cyc();
        checks++;
        if (Door_Open !== 1'b0 || Moving_Up !== 1'b0 || Moving_Down !== 1'b0 ||
            Pending !== 8'h00 || Floor_LED !== 8'h04) begin
            errors++;
            $display("FAIL trip_E12: got door=%b up=%b dn=%b pend=%h led=%b, expected idle at floor 2 with pend=00",
                     Door_Open, Moving_Up, Moving_Down, Pending, Floor_LED);
        end
        $display("test_single_trip done");
    endtask

    task automatic test_same_floor();
        int door_cnt = 0;
        int moved = 0;
        do_reset();
        Call = 8'h01;
        cyc();
        Call = '0;
        checks++;
        if (Pending !== 8'h01 || Door_Open !== 1'b0) begin
            errors++;
            $display("FAIL same_E0: got pend=%h door=%b, expected pend=01 door=0", Pending, Door_Open);
        end
        cyc();
        checks++;
        if (Door_Open !== 1'b1 || Pending !== 8'h00) begin
            errors++;
            $display("FAIL same_E1: got door=%b pend=%h, expected door=1 pend=00", Door_Open, Pending);
        end
        if (Door_Open === 1'b1) door_cnt++;
        repeat (6) begin
            cyc();
            if (Door_Open === 1'b1) door_cnt++;
            if (Moving_Up !== 1'b0 || Moving_Down !== 1'b0) moved++;
        end
        checks++;
        if (door_cnt != D || moved != 0) begin
            errors++;
            $display("FAIL same_dwell: got door_cycles=%0d moving_cycles=%0d, expected door_cycles=%0d moving_cycles=0",
                     door_cnt, moved, D);
        end
        $display("test_same_floor done");
    endtask

    task automatic test_scan();
        int n = 0;
        int flips = 0;
        int lastdir = 1;
        int curdir;
        logic prev_door = 1'b0;
        int stops[$];
        do_reset();
        Call = 8'h40;
        cyc();
        Call = '0;
        while (Floor_Num !== 3'd3 && n < 40) begin
            cyc();
            n++;
        end
        checks++;
        if (Floor_Num !== 3'd3 || Moving_Up !== 1'b1) begin
            errors++;
            $display("FAIL scan_reach3: got num=%0d up=%b, expected num=3 up=1", Floor_Num, Moving_Up);
        end
        Call = 8'h02;
        cyc();
        Call = '0;
        n = 0;
        while (n < 120 && !(stops.size() == 2 && Door_Open === 1'b0)) begin
            cyc();
            n++;
            if (Door_Open === 1'b1 && prev_door === 1'b0) stops.push_back(int'(Floor_Num));
            prev_door = Door_Open;
            if (Moving_Up === 1'b1 || Moving_Down === 1'b1) begin
                curdir = (Moving_Up === 1'b1) ? 1 : 0;
                if (curdir != lastdir) flips++;
                lastdir = curdir;
            end
        end
        checks++;
        if (stops.size() != 2) begin
            errors++;
            $display("FAIL scan_stops: got %0d stops, expected 2", stops.size());
        end else if (stops[0] != 6 || stops[1] != 1) begin
            errors++;
            $display("FAIL scan_order: got stops %0d,%0d, expected 6,1", stops[0], stops[1]);
        end
        checks++;
        if (flips != 1 || Pending !== 8'h00) begin
            errors++;
            $display("FAIL scan_flip: got flips=%0d pend=%h, expected flips=1 pend=00", flips, Pending);
        end
        $display("test_scan done");
    endtask

    task automatic test_enable_freeze();
        int e;
        logic [FW-1:0] held;
        do_reset();
        Call = 8'h10;
        cyc();
        Call = '0;
        repeat (10) cyc();
        held = Floor_Num;
        checks++;
        if (held !== 3'd2) begin
            errors++;
            $display("FAIL freeze_pre: got num=%0d, expected num=2", held);
        end
        Enable = 1'b0;
        cyc();
        Call = 8'h80;
        cyc();
        Call = '0;
        repeat (3) cyc();
        checks++;
        if (Floor_Num !== held || Moving_Up !== 1'b1 || Pending !== 8'h90) begin
            errors++;
            $display("FAIL freeze_hold: got num=%0d up=%b pend=%h, expected num=%0d up=1 pend=90",
                     Floor_Num, Moving_Up, Pending, held);
        end
        Enable = 1'b1;
        e = 15;
        while (Door_Open !== 1'b1 && e < 60) begin
            cyc();
            e++;
        end
        checks++;
        if (e != 22 || Floor_Num !== 3'd4) begin
            errors++;
            $display("FAIL freeze_arrival: got edge=%0d num=%0d, expected edge=22 num=4", e, Floor_Num);
        end
        $display("test_enable_freeze done");
    endtask

    task automatic test_door_extend_reset();
        do_reset();
        Call = 8'h04;
        cyc();
        Call = '0;
        repeat (9) cyc();
        checks++;
        if (Door_Open !== 1'b1 || Floor_Num !== 3'd2) begin
            errors++;
            $display("FAIL extend_arrive: got door=%b num=%0d, expected door=1 num=2", Door_Open, Floor_Num);
        end
        Call = 8'h04;
        cyc();
        Call = '0;
        checks++;
        if (Door_Open !== 1'b1 || Pending !== 8'h00) begin
            errors++;
            $display("FAIL extend_recall: got door=%b pend=%h, expected door=1 pend=00", Door_Open, Pending);
        end
        repeat (2) cyc();
        checks++;
        if (Door_Open !== 1'b1) begin
            errors++;
            $display("FAIL extend_held: got door=%b, expected door=1", Door_Open);
        end
        cyc();
        checks++;
        if (Door_Open !== 1'b0) begin
            errors++;
            $display("FAIL extend_close: got door=%b, expected door=0", Door_Open);
        end
        Call = 8'hA0;
        cyc();
        Call = '0;
        repeat (6) cyc();
        checks++;
        if (Moving_Up !== 1'b1) begin
            errors++;
            $display("FAIL extend_move: got up=%b, expected up=1", Moving_Up);
        end
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (Floor_Num !== 3'd0 || Pending !== 8'h00 || Floor_LED !== 8'h01 ||
            Moving_Up !== 1'b0 || Door_Open !== 1'b0) begin
            errors++;
            $display("FAIL reset_midmove: got num=%0d pend=%h led=%b up=%b door=%b, expected num=0 pend=00 led=00000001 up=0 door=0",
                     Floor_Num, Pending, Floor_LED, Moving_Up, Door_Open);
        end
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        $display("test_door_extend_reset done");
    endtask

    task automatic test_random();
        int r;
        logic [F-1:0]  el;
        logic [FW-1:0] ef;
        logic [F-1:0]  ep;
        logic          eu, ed, eo;
        do_reset();
        for (int k = 0; k < 800; k++) begin
            r = int'($urandom_range(0, 19));
            if (r < 3) Call = F'(1) << $urandom_range(0, F - 1);
            else if (r == 3) Call = F'($urandom);
            else if (r == 4 && m_floor >= 0 && m_floor < F) Call = F'(1) << m_floor;
            else Call = '0;
            Enable = ($urandom_range(0, 7) != 0);
            cyc();
            el = '0;
            if (m_floor >= 0 && m_floor < F) el[m_floor] = 1'b1;
            ef = FW'(m_floor);
            ep = m_pend_vec();
            eu = (m_mode == 1) && (m_dir != 0);
            ed = (m_mode == 1) && (m_dir == 0);
            eo = (m_mode == 2);
            checks++;
            if (Floor_Num !== ef || Floor_LED !== el) begin
                errors++;
                $display("FAIL rand_floor cyc %0d: got num=%0d led=%b, expected num=%0d led=%b",
                         k, Floor_Num, Floor_LED, ef, el);
            end
            checks++;
            if (Pending !== ep) begin
                errors++;
                $display("FAIL rand_pending cyc %0d: got %b, expected %b", k, Pending, ep);
            end
            checks++;
            if (Moving_Up !== eu || Moving_Down !== ed || Door_Open !== eo) begin
                errors++;
                $display("FAIL rand_status cyc %0d: got up=%b dn=%b door=%b, expected up=%b dn=%b door=%b",
                         k, Moving_Up, Moving_Down, Door_Open, eu, ed, eo);
            end
        end
        Call = '0;
        Enable = 1'b1;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single_trip();
        test_same_floor();
        test_scan();
        test_enable_freeze();
        test_door_extend_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl_nfloor.md
# elevator_ctrl_nfloor

Parametrised N-floor elevator controller, the successor to the three-floor up/down FSM. It latches per-floor call requests into a pending register and serves them in SCAN order: it keeps travelling in the current direction while requests lie ahead, then reverses. Floor travel time and door dwell time are timed in clock cycles. It sits between the call-button/debounce logic and the floor-indicator and door drivers.

## Interface
- FLOORS, 8: number of floors, ≥2; floors are numbered 0..FLOORS-1.
- TRAVEL_CYCLES, 4: cycles spent in MOVE per one-floor step, ≥1.
- DOOR_CYCLES, 3: cycles Door_Open stays high per stop, ≥1.
- FW (localparam) = $clog2(FLOORS).

Ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- Enable  in  1  when low, FSM, floor, direction and timers hold; Call is still latched.
- Call  in  FLOORS  per-floor request pulses; any width, may be multi-hot.
- Floor_LED  out  FLOORS  one-hot current floor.
- Floor_Num  out  FW  binary current floor.
- Moving_Up / Moving_Down  out  1 each  high only in MOVE, per direction.
- Door_Open  out  1  high in DOOR.
- Pending  out  FLOORS  registered outstanding requests.

## Operation
- Reset values: state IDLE, Floor_Num=0, Floor_LED=1, dir=up, Pending=0, Door_Open=0, Moving_*=0, both timers 0.
- Pending update each edge, regardless of Enable: Pending <= (Pending | Call) & ~clr.
  - clr is the bit of a floor being served.
  - A Call bit for the current floor while in DOOR is not latched.
- All decisions use registered Pending, never raw Call.
- ahead = any Pending bit strictly above the floor (dir up) or strictly below it (dir down). behind is the opposite side.
- IDLE:
  - Pending[floor] set: go to DOOR and clear that bit.
  - else ahead: go to MOVE.
  - else behind: flip dir and go to MOVE.
  - else stay in IDLE.
- MOVE:
  - travel timer counts 0..TRAVEL_CYCLES-1.
  - At TRAVEL_CYCLES-1, floor steps ±1 and the timer returns to 0.
  - On the same edge, if Pending[new floor] is set: go to DOOR, clear the bit and load the door timer. Otherwise stay in MOVE.
- DOOR:
  - door timer counts DOOR_CYCLES cycles, then the IDLE decision rules apply on that edge: DOOR goes to MOVE (same or flipped dir) or to IDLE.
  - A Call for the current floor during DOOR reloads the door timer, extending Door_Open.
- Floor never leaves the range 0..FLOORS-1 (guaranteed by the ahead logic). An assertion must flag any attempted step past an end floor.
- Illegal state encoding recovers to IDLE on the next edge.

## Timing
- Call registered at edge E0 → Pending visible after E0 → FSM acts at E1.
- Trip of k floors from IDLE: MOVE entered at E1; floor i reached at E1 + i·TRAVEL_CYCLES; Door_Open rises on the arrival edge.
- Door_Open stays high for exactly DOOR_CYCLES cycles, unless reloaded.
- Enable low freezes all timers mid-count; they resume with no cycles lost or added.
- RST mid-MOVE or mid-DOOR: immediate return to reset values and Pending is cleared.
- Simultaneous Call on the served floor and the clr of that floor: clr wins, and the request counts as served.

## Test plan
- Reset: assert RST asynchronously mid-cycle → outputs equal reset values immediately; Floor_LED=8'b0000_0001.
- Single trip (FLOORS=8, TRAVEL=4, DOOR=3): pulse Call[2] at E0 → MOVE at E1; Floor_Num=1 at E5; Floor_Num=2 with Door_Open at E9; IDLE at E12; Pending=0.
- Same-floor call: at floor 0 in IDLE, pulse Call[0] → Door_Open at E1 for 3 cycles; Moving_* never high.
- SCAN order: at floor 3 moving up, Call[1] and Call[6] pending → stops at 6 first, then reverses and stops at 1; dir flips exactly once.
- Enable freeze: drop Enable for 5 cycles mid-MOVE and pulse Call[7] → Floor_Num and timer held; Pending[7] set; arrival delayed by exactly 5 cycles.
- Door extend and reset mid-op: Call[cur] during DOOR → Door_Open lasts 3 cycles past the re-call. Then RST during the next MOVE → Floor_Num=0, Pending=0.
